multicycle_cu: RTL

Parametrised next-generation multicycle RISC-V control FSM: the main decoder driving the shared-memory datapath (PC, IR, MDR, register file, ALU, ALUOut). Extends the fixed-timing 13-state control unit with a memory ready handshake, a configurable memory-wait timeout, an illegal-opcode/timeout trap state with cause, and a retire pulse. Sits between the IR opcode field and the datapath mux/enable lines.

---
 rtl/multicycle_cu.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// Multicycle RISC-V main control FSM with memory ready handshake, wait timeout,
// illegal-opcode/timeout trap with cause, and an instruction-retired pulse.
module multicycle_cu #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          TRAP_HALT   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       instr_retired
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StWbMem  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StWbAlu  = 4'd7,
        StBranch = 4'd8,
        StJal    = 4'd9,
        StJalr   = 4'd10,
        StUpper  = 4'd11,
        StTrap   = 4'd12
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    // Wide enough to hold MEM_TIMEOUT itself; one bit when timeout is disabled.
    localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]        trap_cause_q, trap_cause_d;
    logic              timeout_hit;
    logic              in_mem_state;

    assign timeout_hit  = (MEM_TIMEOUT != 0) && ((32'(wait_cnt_q) + 32'd1) >= MEM_TIMEOUT);
    assign in_mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        pc_source     = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        trap          = 1'b0;
        instr_retired = 1'b0;
        state_d       = state_q;
        trap_cause_d  = trap_cause_q;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d      = StTrap;
                    trap_cause_d = CauseTimeout;
                end
            end
            StDecode: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR, OpI:        state_d = StExec;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui, OpAuipc:  state_d = StUpper;
                    default: begin
                        state_d      = StTrap;
                        trap_cause_d = CauseIllegal;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (op == OpLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = StWbMem;
                end else if (timeout_hit) begin
                    state_d      = StTrap;
                    trap_cause_d = CauseTimeout;
                end
            end
            StWbMem: begin
                reg_write     = 1'b1;
                mem_to_reg    = 2'b01;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StMemWr: begin
                mem_write     = 1'b1;
                i_or_d        = 1'b1;
                instr_retired = mem_ready;
                if (mem_ready) begin
                    state_d = StFetch;
                end else if (timeout_hit) begin
                    state_d      = StTrap;
                    trap_cause_d = CauseTimeout;
                end
            end
            StExec: begin
                alu_src_a = 2'b01;
                alu_src_b = op[5] ? 2'b00 : 2'b10;
                alu_op    = 2'b10;
                state_d   = StWbAlu;
            end
            StWbAlu: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                alu_src_a     = 2'b01;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StJal: begin
                pc_write      = 1'b1;
                pc_source     = 2'b01;
                reg_write     = 1'b1;
                mem_to_reg    = 2'b10;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StJalr: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b10;
                pc_write      = 1'b1;
                reg_write     = 1'b1;
                mem_to_reg    = 2'b10;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StUpper: begin
                reg_write     = 1'b1;
                mem_to_reg    = op[5] ? 2'b11 : 2'b00;
                instr_retired = 1'b1;
                state_d       = StFetch;
            end
            StTrap: begin
                trap    = 1'b1;
                state_d = TRAP_HALT ? StTrap : StFetch;
            end
            default: begin
                // Unused encodings fall into the trap as if the opcode were illegal.
                state_d      = StTrap;
                trap_cause_d = CauseIllegal;
            end
        endcase
    end

    // Counter restarts on every entry to a memory state and only counts while stalled.
    always_comb begin
        wait_cnt_d = '0;
        if (in_mem_state && (state_d == state_q)) begin
            wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFetch;
            wait_cnt_q   <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign state      = state_q;
    assign trap_cause = trap_cause_q;

endmodule
